// File: rtl/kob_bank_arb_if.sv
// Channel request/ack handshake, bank enables and per-bank issue outputs
// of the bank arbiter, bundled as one interface.
interface kob_bank_arb_if;
    logic       d_ch_0_rob_req;
    logic       d_ch_1_rob_req;
    logic       d_ch_2_rob_req;
    logic [1:0] d_ch_0_rob_bank_id;
    logic [1:0] d_ch_1_rob_bank_id;
    logic [1:0] d_ch_2_rob_bank_id;
    logic       d_ch_0_rob_ack;
    logic       d_ch_1_rob_ack;
    logic       d_ch_2_rob_ack;
    logic [3:0] cfg_bank_en;
    logic [3:0] bank_issue_valid;
    logic [7:0] bank_issue_ch;
    logic [3:0] bank_busy;

    modport slave (
        input  d_ch_0_rob_req, d_ch_1_rob_req, d_ch_2_rob_req,
        input  d_ch_0_rob_bank_id, d_ch_1_rob_bank_id, d_ch_2_rob_bank_id,
        input  cfg_bank_en,
        output d_ch_0_rob_ack, d_ch_1_rob_ack, d_ch_2_rob_ack,
        output bank_issue_valid, bank_issue_ch, bank_busy
    );

    modport master (
        output d_ch_0_rob_req, d_ch_1_rob_req, d_ch_2_rob_req,
        output d_ch_0_rob_bank_id, d_ch_1_rob_bank_id, d_ch_2_rob_bank_id,
        output cfg_bank_en,
        input  d_ch_0_rob_ack, d_ch_1_rob_ack, d_ch_2_rob_ack,
        input  bank_issue_valid, bank_issue_ch, bank_busy
    );
endinterface

// File: rtl/kob_bank_arb.sv
// Three-channel to four-bank arbiter: per-bank round-robin selection with a
// BANK_LAT-cycle occupancy window and a registered per-bank issue pulse.
module kob_bank_arb #(
    parameter int BANK_LAT = 4
) (
    input logic           clk,
    input logic           rstn,
    kob_bank_arb_if.slave bus
);
    localparam logic [3:0] LAT_LOAD = 4'(BANK_LAT - 1);

    logic [2:0] req;
    logic [1:0] bank_id [3];
    logic [3:0] busy_cnt [4];
    logic [1:0] rr_ptr [4];
    logic [3:0] gnt_vld;
    logic [1:0] gnt_ch [4];
    logic [2:0] ack;
    logic [3:0] issue_vld_p1;
    logic [7:0] issue_ch_p1;

    // (ptr + k) mod 3 for ptr in 0..2, k in 0..2
    function automatic logic [1:0] rr_idx(input logic [1:0] ptr, input int k);
        logic [2:0] s;
        s = 3'(ptr) + 3'(k);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

    assign req        = {bus.d_ch_2_rob_req, bus.d_ch_1_rob_req, bus.d_ch_0_rob_req};
    assign bank_id[0] = bus.d_ch_0_rob_bank_id;
    assign bank_id[1] = bus.d_ch_1_rob_bank_id;
    assign bank_id[2] = bus.d_ch_2_rob_bank_id;

    always_comb begin
        gnt_vld = '0;
        ack     = '0;
        for (int b = 0; b < 4; b++) begin
            gnt_ch[b] = 2'd0;
            if (busy_cnt[b] == 4'd0 && bus.cfg_bank_en[b]) begin
                for (int k = 0; k < 3; k++) begin
                    if (!gnt_vld[b] && req[rr_idx(rr_ptr[b], k)] &&
                        bank_id[rr_idx(rr_ptr[b], k)] == 2'(b)) begin
                        gnt_vld[b] = 1'b1;
                        gnt_ch[b]  = rr_idx(rr_ptr[b], k);
                    end
                end
            end
        end
        // a channel targets exactly one bank, so at most one bank can ack it
        for (int b = 0; b < 4; b++) begin
            if (gnt_vld[b]) ack[gnt_ch[b]] = 1'b1;
        end
        if (!rstn) ack = '0;
    end

    assign bus.d_ch_0_rob_ack = ack[0];
    assign bus.d_ch_1_rob_ack = ack[1];
    assign bus.d_ch_2_rob_ack = ack[2];

    // stage p1: grant registered into the per-bank issue outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int b = 0; b < 4; b++) begin
                busy_cnt[b] <= 4'd0;
                rr_ptr[b]   <= 2'd0;
            end
            issue_vld_p1 <= '0;
            issue_ch_p1  <= '0;
        end else begin
            issue_vld_p1 <= gnt_vld;
            for (int b = 0; b < 4; b++) begin
                if (gnt_vld[b]) begin
                    busy_cnt[b]            <= LAT_LOAD;
                    rr_ptr[b]              <= rr_idx(gnt_ch[b], 1);
                    issue_ch_p1[2*b +: 2]  <= gnt_ch[b];
                end else if (busy_cnt[b] != 4'd0) begin
                    busy_cnt[b] <= busy_cnt[b] - 4'd1;
                end
            end
        end
    end

    always_comb begin
        for (int b = 0; b < 4; b++) bus.bank_busy[b] = (busy_cnt[b] != 4'd0);
    end

    assign bus.bank_issue_valid = issue_vld_p1;
    assign bus.bank_issue_ch    = issue_ch_p1;
endmodule
